// File: rtl/slice_addsub_if.sv
// Request/result bundle for the digit-serial adder/subtractor.
// Latency: none (wires only); the block behind it answers WIDTH/SLICE cycles after start.
// Backpressure: start is only honoured while busy is low; there is no result-side stall.
interface slice_addsub_if #(
  parameter int WIDTH = 16
) ();

  // Request side
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;

  // Status / result side
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  // Requester: issues operations and watches status/results.
  modport master (
    output start, op, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  // Arithmetic block: consumes operations and produces results.
  modport slave (
    input  start, op, a, b, cin,
    output busy, done, sum, cout, overflow
  );

endinterface

// File: rtl/slice_addsub.sv
// Multi-cycle add/subtract, SLICE bits per clock, LSB digit first, one carry register between digits.
// Latency: WIDTH/SLICE cycles from the accepting edge to the done pulse (1 cycle when SLICE == WIDTH).
// Backpressure: start is ignored while busy; results are registered and held until the next completion.
// Optional build macro SLICE_ADDSUB_SAT_EN: saturate sum on signed overflow instead of wrapping.
module slice_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst,
  slice_addsub_if.slave bus
);

  // Number of digit cycles and the width of the digit counter.
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject configurations that cannot be split into whole digits.
  generate
    if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("slice_addsub: WIDTH must be >= 2 and a multiple of SLICE");
    end
  endgenerate

  // Op codes; anything that is neither ADD nor SUB produces a zero result.
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Control state
  state_t                    state_q;
  logic [CW-1:0]             cnt_q;
  logic                      carry_q;
  logic                      sub_q;
  logic                      nop_q;

  // Operands as digit arrays so the active digit is a plain array index.
  logic [N-1:0][SLICE-1:0]   a_q;
  logic [N-1:0][SLICE-1:0]   beff_q;
  logic [N-1:0][SLICE-1:0]   part_q;

  // Registered results and status
  logic [WIDTH-1:0]          sum_q;
  logic                      cout_q;
  logic                      ovf_q;
  logic                      busy_q;
  logic                      done_q;

  // Operand capture values formed from the bus at the accepting edge
  logic                      is_add;
  logic                      is_sub;
  logic [WIDTH-1:0]          a_d;
  logic [WIDTH-1:0]          beff_d;
  logic                      c0_d;

  // Per-cycle digit arithmetic
  logic [SLICE:0]            slice_sum;
  logic [N-1:0][SLICE-1:0]   part_d;
  logic                      last_slice;
  logic                      ovf_raw;
  logic                      cout_d;
  logic [WIDTH-1:0]          res_d;

  assign is_add = (bus.op == OP_ADD);
  assign is_sub = (bus.op == OP_SUB);

  // Subtraction is a + ~b + ~cin, so a borrow-in becomes a missing carry-in.
  // NOP/reserved zero everything so the datapath naturally yields 0.
  always_comb begin
    a_d    = '0;
    beff_d = '0;
    c0_d   = 1'b0;
    if (is_add) begin
      a_d    = bus.a;
      beff_d = bus.b;
      c0_d   = bus.cin;
    end else if (is_sub) begin
      a_d    = bus.a;
      beff_d = ~bus.b;
      c0_d   = ~bus.cin;
    end
  end

  // Add the current digit, splice it into the partial result and derive completion values.
  always_comb begin
    slice_sum       = {1'b0, a_q[cnt_q]} + {1'b0, beff_q[cnt_q]} + {{SLICE{1'b0}}, carry_q};
    part_d          = part_q;
    part_d[cnt_q]   = slice_sum[SLICE-1:0];
    last_slice      = (cnt_q == CW'(N - 1));
    // Same-sign operands whose raw result flips sign have overflowed.
    ovf_raw         = (a_q[N-1][SLICE-1] == beff_q[N-1][SLICE-1]) &&
                      (part_d[N-1][SLICE-1] != a_q[N-1][SLICE-1]) && !nop_q;
    // Subtraction reports borrow, which is the inverted final carry.
    cout_d          = nop_q ? 1'b0 : (sub_q ? ~slice_sum[SLICE] : slice_sum[SLICE]);
    res_d           = part_d;
`ifdef SLICE_ADDSUB_SAT_EN
    // Clamp toward the sign of a: positive overflow -> max positive, negative -> most negative.
    if (ovf_raw) begin
      res_d = a_q[N-1][SLICE-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Control FSM: capture operands in IDLE, walk the digits in RUN, publish results on the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      nop_q   <= 1'b0;
      a_q     <= '0;
      beff_q  <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= a_d;
            beff_q  <= beff_d;
            carry_q <= c0_d;
            sub_q   <= is_sub;
            nop_q   <= !(is_add || is_sub);
            part_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          part_q  <= part_d;
          carry_q <= slice_sum[SLICE];
          if (last_slice) begin
            sum_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_raw;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/slice_addsub.md
Name: slice_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor. Successor to the fixed 16-bit combinational ripple adder in the integer ALU.
- Processes operands in SLICE-bit digits, least significant first, over WIDTH/SLICE clock cycles. Keeps one carry register between slices.
- Uses a start/busy/done handshake and registered results, so the ALU can trade latency for a short carry chain at any width.
- Op encoding and flag semantics match the existing ALU adder: 01 = add, 11 = subtract with borrow, other codes = zero result.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be at least 2.
- SLICE, 4, bits processed per cycle. Must divide WIDTH exactly; elaboration fails otherwise.
- N (derived, localparam) = WIDTH/SLICE, number of processing cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation. Sampled only when busy=0.
- op  input  2  00 = NOP, 01 = ADD, 11 = SUB, 10 = reserved (behaves as NOP).
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- cin  input  1  carry-in for ADD, borrow-in for SUB. Captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result registers update.
- sum  output  WIDTH  registered result.
- cout  output  1  carry-out for ADD, borrow-out for SUB, 0 for NOP.
- overflow  output  1  signed two's-complement overflow, 0 for NOP.

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0, FSM in IDLE, slice counter 0, carry register 0, internal operand registers 0.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on start=1 at a clock edge.
  - RUN -> IDLE at the edge that processes slice N-1.
- Start accepted at edge k:
  - Latch a, b, cin and op.
  - Form the effective operand: beff = b, c0 = cin for ADD; beff = ~b, c0 = ~cin for SUB; a, b and c0 treated as 0 for NOP/reserved.
  - busy=1 after edge k.
- Slice processing: slice i = bits [i*SLICE +: SLICE], processed at edge k+1+i for i = 0..N-1.
  - Each slice: slice sum = a_slice + beff_slice + carry register.
  - Slice sum bits go into an internal partial-result register; carry-out goes into the carry register.
- Completion at edge k+N:
  - sum, cout and overflow load from the final slice.
  - done=1 for exactly one cycle; busy=0.
  - Latency from start acceptance to done is N cycles. For N=1 it is 1 cycle.
- sum, cout and overflow hold their previous values during RUN. They change only at completion or reset.
- cout rule: ADD gives the final carry; SUB gives the inverted final carry (1 = borrow, i.e. a < b+cin unsigned); NOP gives 0.
- overflow rule: 1 when a[WIDTH-1] == beff[WIDTH-1] and raw sum[WIDTH-1] != a[WIDTH-1]; forced to 0 for NOP/reserved.
- Handshake boundary cases:
  - start while busy=1 is ignored. The operation in progress is unaffected.
  - start high in the same cycle as done is accepted, because busy is already 0. Back-to-back throughput is one operation per N cycles.
  - start held high continuously produces a new operation after every done.
  - Input changes after the accepting edge have no effect.
- Reset during RUN: at the rst edge the block returns to IDLE, all outputs clear and no done pulse is issued. rst has priority over start.
- Arithmetic is modulo 2^WIDTH. No other state exists.

Optional Feature:
- Macro: SLICE_ADDSUB_SAT_EN.
- Defined: on completion with overflow=1, sum saturates instead of wrapping.
  - a[WIDTH-1]=0 saturates to {0,{WIDTH-1{1}}} (largest positive value).
  - a[WIDTH-1]=1 saturates to {1,{WIDTH-1{0}}} (most negative value).
  - overflow and cout still report the unsaturated condition.
  - Latency is unchanged.
- Undefined: sum always wraps modulo 2^WIDTH. No saturation logic is present.

Test Plan:
- WIDTH=16, SLICE=4. ADD a=0x1234, b=0x0FFF, cin=0 -> done exactly 4 cycles after start; sum=0x2233, cout=0, overflow=0. busy is high for 4 cycles; sum holds its old value until done.
- ADD a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. ADD a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
- SUB a=0x0003, b=0x0005, cin=1 -> sum=0xFFFD, cout=1 (borrow), overflow=0. SUB a=0x8000, b=0x0001, cin=0 -> sum=0x7FFF, cout=0, overflow=1. With SLICE_ADDSUB_SAT_EN the second case gives sum=0x8000, overflow=1.
- Handshake:
  - A second start 2 cycles into RUN is ignored; only one done pulse appears.
  - start in the done cycle is accepted, and the next done follows 4 cycles later.
  - rst asserted mid-RUN -> next cycle busy=0, done=0, sum=0, cout=0, overflow=0, and no done pulse follows.
- op=00 and op=10 with a=0xAAAA, b=0x5555, cin=1 -> after 4 cycles sum=0x0000, cout=0, overflow=0, done pulses.
- WIDTH=32, SLICE=8: ADD a=0xFFFFFFFF, b=0, cin=1 -> done after 4 cycles, sum=0, cout=1, overflow=0. WIDTH=16, SLICE=16: ADD 0x1234+0x0FFF -> done after 1 cycle, sum=0x2233.
